// File: rtl/mt_reg_file_sb_if.sv
// mt_reg_file_sb_if
//   Bundles the read, write, scoreboard and clear signals of mt_reg_file_sb.
//   master: the pipeline side (drives addresses, writes, scoreboard and clear
//           requests; receives read data, busy flags and status).
//   slave : the register file itself.
//   Signals:
//     tid_read, a1, a2        read thread and read addresses
//     rd1, rd2, busy1, busy2  read data and pending-write flags
//     write_enable, tid_write, a3, wd3, wr_drop   write port and drop flag
//     pend_set, pend_tid, pend_reg                scoreboard set request
//     clr_req, clr_tid                            per-thread clear request
//     ready, clr_busy                             engine status
interface mt_reg_file_sb_if #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int NUM_REGS     = 32,
    parameter int BITS_REGS    = $clog2(NUM_REGS),
    parameter int DATA_WIDTH   = 32
);
    logic [BITS_THREADS-1:0] tid_read;
    logic [BITS_REGS-1:0]    a1;
    logic [BITS_REGS-1:0]    a2;
    logic [DATA_WIDTH-1:0]   rd1;
    logic [DATA_WIDTH-1:0]   rd2;
    logic                    busy1;
    logic                    busy2;
    logic                    write_enable;
    logic [BITS_THREADS-1:0] tid_write;
    logic [BITS_REGS-1:0]    a3;
    logic [DATA_WIDTH-1:0]   wd3;
    logic                    wr_drop;
    logic                    pend_set;
    logic [BITS_THREADS-1:0] pend_tid;
    logic [BITS_REGS-1:0]    pend_reg;
    logic                    clr_req;
    logic [BITS_THREADS-1:0] clr_tid;
    logic                    ready;
    logic                    clr_busy;

    modport master (
        output tid_read, a1, a2, write_enable, tid_write, a3, wd3,
               pend_set, pend_tid, pend_reg, clr_req, clr_tid,
        input  rd1, rd2, busy1, busy2, wr_drop, ready, clr_busy
    );

    modport slave (
        input  tid_read, a1, a2, write_enable, tid_write, a3, wd3,
               pend_set, pend_tid, pend_reg, clr_req, clr_tid,
        output rd1, rd2, busy1, busy2, wr_drop, ready, clr_busy
    );
endinterface

// File: rtl/mt_reg_file_sb.sv
// mt_reg_file_sb
//   Per-thread register file for the barrel pipeline decode stage.
//   - Two combinational read ports, one write port, register 0 hardwired to 0.
//   - Optional bypass of a same-cycle accepted write onto the read ports.
//   - Clear engine: zeroes the whole array after reset (CLEAR_ALL) and one
//     thread on request (CLEAR_THR), one entry per cycle.
//   - Pending-write scoreboard (one bit per thread/register) for issue hazards.
//   Ports:
//     clk  clock, all state on the rising edge
//     rst  synchronous reset, active high
//     bus  mt_reg_file_sb_if.slave (read/write/scoreboard/clear/status)
module mt_reg_file_sb #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int NUM_REGS     = 32,
    parameter int BITS_REGS    = $clog2(NUM_REGS),
    parameter int DATA_WIDTH   = 32,
    parameter int BYPASS       = 1
) (
    input  logic              clk,
    input  logic              rst,
    mt_reg_file_sb_if.slave   bus
);
    localparam int TOTAL = NUM_THREADS * NUM_REGS;
    localparam int IDX_W = BITS_THREADS + BITS_REGS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_THR = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic                                   ready_q, ready_d;
    logic                                   clr_busy_q, clr_busy_d;
    logic [NUM_THREADS-1:0][NUM_REGS-1:0]   pend_q, pend_d;

    logic [DATA_WIDTH-1:0]                  mem_q [TOTAL];

    logic                                   wr_accept;
    logic                                   clr_start;
    logic                                   mem_we;
    logic [IDX_W-1:0]                       mem_waddr;
    logic [DATA_WIDTH-1:0]                  mem_wdata;
    logic                                   thr_clearing;

    // Writes are only taken in IDLE; x0 writes are silently discarded.
    assign wr_accept = (state_q == IDLE) && bus.write_enable &&
                       (bus.a3 != '0) && !rst;

    assign bus.wr_drop  = bus.write_enable && (state_q != IDLE);
    assign bus.ready    = ready_q;
    assign bus.clr_busy = clr_busy_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ALL;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            clr_busy_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            clr_busy_q <= clr_busy_d;
            pend_q     <= pend_d;
        end
    end

    // Next state and the single array write port. The clear engine and the
    // user write never compete: user writes are only possible in IDLE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clr_start = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = '0;
        case (state_q)
            CLEAR_ALL: begin
                mem_we = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            IDLE: begin
                if (wr_accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = {bus.tid_write, bus.a3};
                    mem_wdata = bus.wd3;
                end
                if (bus.clr_req) begin
                    state_d   = CLEAR_THR;
                    idx_d     = {bus.clr_tid, {BITS_REGS{1'b0}}};
                    clr_start = 1'b1;
                end
            end
            CLEAR_THR: begin
                mem_we = 1'b1;
                // Last register of the thread: idx stays inside the thread.
                if (idx_q[BITS_REGS-1:0] == {BITS_REGS{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR_ALL;
                idx_d   = '0;
            end
        endcase
        ready_d    = (state_d == IDLE);
        clr_busy_d = (state_d == CLEAR_THR);
    end

    // Scoreboard update order gives the required priorities:
    // write-clear < pend_set < thread clear.
    always_comb begin
        pend_d = pend_q;
        if (wr_accept) begin
            pend_d[bus.tid_write][bus.a3] = 1'b0;
        end
        if ((state_q == IDLE) && bus.pend_set && (bus.pend_reg != '0)) begin
            pend_d[bus.pend_tid][bus.pend_reg] = 1'b1;
        end
        if (clr_start) begin
            pend_d[bus.clr_tid] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // The thread under clear reads as zero even for entries not yet reached.
    assign thr_clearing = (state_q == CLEAR_THR) &&
                          (bus.tid_read == idx_q[IDX_W-1:BITS_REGS]);

    logic [BITS_REGS-1:0] rd_addr [2];
    assign rd_addr[0] = bus.a1;
    assign rd_addr[1] = bus.a2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] data;
            logic                  busy;
            logic                  hit;
            always_comb begin
                hit  = (BYPASS != 0) && wr_accept &&
                       (bus.tid_write == bus.tid_read) &&
                       (bus.a3 == rd_addr[gi]);
                data = mem_q[{bus.tid_read, rd_addr[gi]}];
                busy = pend_q[bus.tid_read][rd_addr[gi]];
                if ((rd_addr[gi] == '0) || (state_q == CLEAR_ALL) || thr_clearing) begin
                    data = '0;
                    busy = 1'b0;
                end else if (hit) begin
                    data = bus.wd3;
                    busy = 1'b0;
                end
            end
        end
    endgenerate

    assign bus.rd1   = g_rd[0].data;
    assign bus.rd2   = g_rd[1].data;
    assign bus.busy1 = g_rd[0].busy;
    assign bus.busy2 = g_rd[1].busy;
endmodule
